// File: rtl/fpgaminer_work_ctrl.sv
// Avalon-MM work controller for the fpgaminer hashing core: shadow work registers,
// commit/run sequencing over a nonce range, and a golden-nonce FIFO drained by software.
module fpgaminer_work_ctrl #(
  parameter int GN_FIFO_DEPTH = 8,
  parameter int NONCE_STEP    = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [4:0]   avs_address,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic         avs_read,
  output logic [31:0]  avs_readdata,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic [31:0]  nonce,
  output logic         hash_en,
  output logic         work_load,
  input  logic         golden_valid,
  input  logic [31:0]  golden_nonce
);

  localparam int PTR_W = $clog2(GN_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] A_CTRL   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h11;
  localparam logic [4:0] A_NSTART = 5'h12;
  localparam logic [4:0] A_NEND   = 5'h13;
  localparam logic [4:0] A_NCUR   = 5'h14;
  localparam logic [4:0] A_GNPOP  = 5'h15;
  localparam logic [4:0] A_GNCNT  = 5'h16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0][31:0]    r_sh_d2;
  logic [7:0][31:0]    r_sh_ms;
  logic [31:0]         r_nonce_start;
  logic [31:0]         r_nonce_end;
  logic                r_overflow;
  logic                r_exhausted;
  logic [31:0]         r_gn_mem [GN_FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_gn_count;

  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_stop;
  logic        w_fclr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_running;
  logic [31:0] w_gn_head;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  // STOP dominates START when both bits arrive in one write
  assign w_ctrl_wr  = avs_write && (avs_address == A_CTRL);
  assign w_start    = w_ctrl_wr && avs_writedata[0] && !avs_writedata[1];
  assign w_stop     = w_ctrl_wr && avs_writedata[1];
  assign w_fclr     = w_ctrl_wr && avs_writedata[2];

  assign w_empty    = (r_gn_count == '0);
  assign w_full     = (r_gn_count == CNT_W'(GN_FIFO_DEPTH));
  assign w_pop      = avs_read && (avs_address == A_GNPOP) && !w_empty && !w_fclr;
  assign w_push_req = golden_valid && !w_fclr;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_gn_head  = w_empty ? 32'h0 : r_gn_mem[r_rd_ptr];

  assign w_running  = (r_state == S_LOAD) || (r_state == S_RUN);
  assign w_status   = {27'h0, r_exhausted, r_overflow, w_full, w_empty, w_running};

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    hash_en     = 1'b0;
    work_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        work_load = 1'b1;
        if (w_stop)       w_state_nxt = S_IDLE;
        else if (w_start) w_state_nxt = S_LOAD;
        else              w_state_nxt = S_RUN;
      end
      S_RUN: begin
        hash_en = 1'b1;
        if (w_stop)                       w_state_nxt = S_IDLE;
        else if (w_start)                 w_state_nxt = S_LOAD;
        else if (nonce == r_nonce_end)    w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = w_start ? S_LOAD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Work is committed on entry to LOAD so it is already on the outputs while work_load is high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_d2       <= '0;
      r_sh_ms       <= '0;
      r_nonce_start <= 32'h0;
      r_nonce_end   <= 32'hFFFF_FFFF;
      midstate      <= '0;
      data2         <= '0;
      nonce         <= 32'h0;
      r_exhausted   <= 1'b0;
    end else begin
      if (avs_write && !avs_address[4]) begin
        if (avs_address[3]) r_sh_ms[avs_address[2:0]] <= avs_writedata;
        else                r_sh_d2[avs_address[2:0]] <= avs_writedata;
      end
      if (avs_write && (avs_address == A_NSTART)) r_nonce_start <= avs_writedata;
      if (avs_write && (avs_address == A_NEND))   r_nonce_end   <= avs_writedata;

      if (w_state_nxt == S_LOAD) begin
        midstate    <= r_sh_ms;
        data2       <= r_sh_d2;
        nonce       <= r_nonce_start;
        r_exhausted <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_state_nxt == S_RUN)  nonce       <= nonce + 32'(NONCE_STEP);
        if (w_state_nxt == S_DONE) r_exhausted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_gn_mem[r_wr_ptr] <= golden_nonce;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || w_fclr) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_gn_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_gn_count <= r_gn_count + CNT_W'(1);
        2'b01:   r_gn_count <= r_gn_count - CNT_W'(1);
        default: r_gn_count <= r_gn_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_rd_data = 32'h0;
    if (!avs_address[4]) begin
      w_rd_data = avs_address[3] ? r_sh_ms[avs_address[2:0]] : r_sh_d2[avs_address[2:0]];
    end else begin
      case (avs_address)
        A_STATUS: w_rd_data = w_status;
        A_NSTART: w_rd_data = r_nonce_start;
        A_NEND:   w_rd_data = r_nonce_end;
        A_NCUR:   w_rd_data = nonce;
        A_GNPOP:  w_rd_data = w_gn_head;
        A_GNCNT:  w_rd_data = 32'(r_gn_count);
        default:  w_rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)      avs_readdata <= 32'h0;
    else if (avs_read) avs_readdata <= w_rd_data;
    else               avs_readdata <= 32'h0;
  end

endmodule

// File: tb/tb_fpgaminer_work_ctrl.sv
// Directed bench for fpgaminer_work_ctrl: register table, run sequencing, nonce wrap,
// golden FIFO corner cases and mid-run reset.
module tb_fpgaminer_work_ctrl;

  logic         clk;
  logic         reset_n;
  logic [4:0]   avs_address;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic         avs_read;
  logic [31:0]  avs_readdata;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic [31:0]  nonce;
  logic         hash_en;
  logic         work_load;
  logic         golden_valid;
  logic [31:0]  golden_nonce;

  fpgaminer_work_ctrl #(.GN_FIFO_DEPTH(8), .NONCE_STEP(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .midstate(midstate), .data2(data2), .nonce(nonce),
    .hash_en(hash_en), .work_load(work_load),
    .golden_valid(golden_valid), .golden_nonce(golden_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] A_CTRL = 5'h10, A_STATUS = 5'h11, A_NSTART = 5'h12,
                         A_NEND = 5'h13, A_NCUR = 5'h14, A_GNPOP = 5'h15, A_GNCNT = 5'h16;

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tv[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  int          wl_cnt  = 0;
  logic [31:0] nq[$];
  logic [31:0] rdv;

  always @(negedge clk) begin
    if (mon_en) begin
      if (work_load) wl_cnt++;
      if (hash_en)   nq.push_back(nonce);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic gpush(input logic [31:0] v);
    @(negedge clk);
    golden_valid = 1'b1; golden_nonce = v;
    @(negedge clk);
    golden_valid = 1'b0;
  endtask

  task automatic run_collect();
    nq.delete();
    wl_cnt = 0;
    mon_en = 1'b1;
    wr(A_CTRL, 32'h1);
    repeat (12) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic chk_nonces(input string nm, input logic [31:0] exp[]);
    chk({nm, "_len"}, 32'(nq.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      if (k < nq.size()) chk($sformatf("%s_%0d", nm, k), nq[k], exp[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; golden_valid = 1'b0; golden_nonce = '0;

    tv.push_back('{0, 5'h00, 32'h0, 32'h0});
    tv.push_back('{0, 5'h07, 32'h0, 32'h0});
    tv.push_back('{0, 5'h08, 32'h0, 32'h0});
    tv.push_back('{0, 5'h0F, 32'h0, 32'h0});
    tv.push_back('{0, A_CTRL, 32'h0, 32'h0});
    tv.push_back('{0, A_STATUS, 32'h0, 32'h2});
    tv.push_back('{0, A_NSTART, 32'h0, 32'h0});
    tv.push_back('{0, A_NEND, 32'h0, 32'hFFFF_FFFF});
    tv.push_back('{0, A_NCUR, 32'h0, 32'h0});
    tv.push_back('{0, A_GNPOP, 32'h0, 32'h0});
    tv.push_back('{0, A_GNCNT, 32'h0, 32'h0});
    tv.push_back('{0, 5'h1F, 32'h0, 32'h0});
    tv.push_back('{1, A_NSTART, 32'h1234_5678, 32'h0});
    tv.push_back('{0, A_NSTART, 32'h0, 32'h1234_5678});
    tv.push_back('{1, A_NEND, 32'h0000_0055, 32'h0});
    tv.push_back('{0, A_NEND, 32'h0, 32'h0000_0055});
    tv.push_back('{1, A_STATUS, 32'hFFFF_FFFF, 32'h0});
    tv.push_back('{0, A_STATUS, 32'h0, 32'h2});
    tv.push_back('{1, A_NCUR, 32'h5, 32'h0});
    tv.push_back('{0, A_NCUR, 32'h0, 32'h0});
    tv.push_back('{1, A_GNCNT, 32'h3, 32'h0});
    tv.push_back('{0, A_GNCNT, 32'h0, 32'h0});
    tv.push_back('{1, 5'h1A, 32'h7, 32'h0});
    tv.push_back('{0, 5'h1A, 32'h0, 32'h0});
    tv.push_back('{1, 5'h03, 32'hCAFE_F00D, 32'h0});
    tv.push_back('{0, 5'h03, 32'h0, 32'hCAFE_F00D});

    repeat (3) @(negedge clk);
    chk("rst_hash_en", 32'(hash_en), 32'h0);
    chk("rst_work_load", 32'(work_load), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_nonce", nonce, 32'h0);
    reset_n = 1'b1;

    foreach (tv[i]) begin
      if (tv[i].wr) wr(tv[i].a, tv[i].d);
      else begin
        rd(tv[i].a, rdv);
        chk($sformatf("reg_%02h", tv[i].a), rdv, tv[i].exp);
      end
    end

    // Main run: commit work, nonce 0x10..0x14
    for (int i = 0; i < 16; i++) wr(5'(i), {8{4'(i)}});
    wr(A_NSTART, 32'h10);
    wr(A_NEND, 32'h14);
    run_collect();
    chk("main_work_load_pulses", 32'(wl_cnt), 32'h1);
    chk_nonces("main_nonce", '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14});
    chk("data2_word3", data2[127:96], 32'h3333_3333);
    chk("midstate_word0", midstate[31:0], 32'h8888_8888);
    rd(A_STATUS, rdv);
    chk("main_status", rdv, 32'h12);

    // Wrap through 0xFFFFFFFF
    wr(A_NSTART, 32'hFFFF_FFFE);
    wr(A_NEND, 32'h1);
    run_collect();
    chk_nonces("wrap_nonce", '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1});
    rd(A_STATUS, rdv);
    chk("wrap_status", rdv, 32'h12);

    // Overfill FIFO then drain
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      golden_valid = 1'b1; golden_nonce = 32'hA0 + 32'(k);
    end
    @(negedge clk);
    golden_valid = 1'b0;
    rd(A_GNCNT, rdv);
    chk("ovf_count", rdv, 32'h8);
    rd(A_STATUS, rdv);
    chk("ovf_status", rdv, 32'h1C);
    for (int k = 0; k < 8; k++) begin
      rd(A_GNPOP, rdv);
      chk($sformatf("pop_%0d", k), rdv, 32'hA0 + 32'(k));
    end
    rd(A_GNPOP, rdv);
    chk("pop_empty", rdv, 32'h0);
    rd(A_STATUS, rdv);
    chk("drained_status", rdv, 32'h1A);
    wr(A_CTRL, 32'h4);
    rd(A_STATUS, rdv);
    chk("fclr_status", rdv, 32'h12);

    // Shadow write and STOP while running
    wr(A_NSTART, 32'h0);
    wr(A_NEND, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    wr(5'h08, 32'hDEAD_BEEF);
    chk("midrun_hash_en", 32'(hash_en), 32'h1);
    chk("midrun_midstate", midstate[31:0], 32'h8888_8888);
    wr(A_CTRL, 32'h2);
    chk("stop_hash_en", 32'(hash_en), 32'h0);
    chk("stop_nonce", nonce, 32'h2);
    repeat (3) @(negedge clk);
    rd(A_NCUR, rdv);
    chk("stop_ncur_hold", rdv, 32'h2);
    rd(A_STATUS, rdv);
    chk("stop_status", rdv, 32'h02);

    // START and STOP together stays idle
    nq.delete(); wl_cnt = 0; mon_en = 1'b1;
    wr(A_CTRL, 32'h3);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    chk("startstop_wl", 32'(wl_cnt), 32'h0);
    chk("startstop_hash", 32'(nq.size()), 32'h0);
    rd(A_STATUS, rdv);
    chk("startstop_status", rdv, 32'h02);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 8; k++) gpush(32'hB0 + 32'(k));
    rd(A_STATUS, rdv);
    chk("full_status", rdv, 32'h04);
    @(negedge clk);
    avs_read = 1'b1; avs_address = A_GNPOP; golden_valid = 1'b1; golden_nonce = 32'hB8;
    @(negedge clk);
    avs_read = 1'b0; golden_valid = 1'b0;
    chk("pushpop_data", avs_readdata, 32'hB0);
    rd(A_GNCNT, rdv);
    chk("pushpop_count", rdv, 32'h8);
    rd(A_STATUS, rdv);
    chk("pushpop_status", rdv, 32'h04);
    for (int k = 1; k < 9; k++) begin
      rd(A_GNPOP, rdv);
      chk($sformatf("pp_pop_%0d", k), rdv, 32'hB0 + 32'(k));
    end

    // Pop on empty with simultaneous push
    @(negedge clk);
    avs_read = 1'b1; avs_address = A_GNPOP; golden_valid = 1'b1; golden_nonce = 32'hC0;
    @(negedge clk);
    avs_read = 1'b0; golden_valid = 1'b0;
    chk("emptypop_data", avs_readdata, 32'h0);
    rd(A_GNCNT, rdv);
    chk("emptypop_count", rdv, 32'h1);

    // FIFO_CLR discards a same-cycle push
    @(negedge clk);
    avs_write = 1'b1; avs_address = A_CTRL; avs_writedata = 32'h4;
    golden_valid = 1'b1; golden_nonce = 32'hC1;
    @(negedge clk);
    avs_write = 1'b0; golden_valid = 1'b0;
    rd(A_GNCNT, rdv);
    chk("fclr_push_count", rdv, 32'h0);

    // Reset mid-run
    wr(A_CTRL, 32'h1);
    gpush(32'hD0);
    repeat (2) @(negedge clk);
    chk("prerst_hash_en", 32'(hash_en), 32'h1);
    chk("prerst_midstate", midstate[31:0], 32'hDEAD_BEEF);
    @(negedge clk);
    reset_n = 1'b0; avs_read = 1'b1; avs_address = A_STATUS;
    @(negedge clk);
    chk("rst_run_hash_en", 32'(hash_en), 32'h0);
    chk("rst_run_work_load", 32'(work_load), 32'h0);
    chk("rst_run_nonce", nonce, 32'h0);
    chk("rst_run_midstate", midstate[31:0], 32'h0);
    chk("rst_run_data2", data2[127:96], 32'h0);
    chk("rst_run_readdata", avs_readdata, 32'h0);
    avs_read = 1'b0;
    reset_n = 1'b1;
    rd(A_STATUS, rdv);
    chk("rst_run_status", rdv, 32'h02);
    rd(A_NEND, rdv);
    chk("rst_run_nend", rdv, 32'hFFFF_FFFF);
    rd(A_GNCNT, rdv);
    chk("rst_run_gncnt", rdv, 32'h0);
    rd(5'h08, rdv);
    chk("rst_run_shadow", rdv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
